// File: rtl/ram_responder.sv
// ram_responder: serves 32-bit word requests from the cache arbiter as two 16-bit halfword
// accesses (low half first). Optional macro RAM_RESPONDER_MASK_SKIP_EN skips all-zero-mask write phases.
module ram_responder #(
    parameter int ADDR_WIDTH  = 26,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Schreiben,
    input  logic                  Lesen,
    input  logic [ADDR_WIDTH-1:0] Adresse,
    input  logic [31:0]           SchreibDaten,
    input  logic [3:0]            WriteMask,
    output logic [31:0]           LeseDaten,
    output logic                  RAMFertig,
    output logic [ADDR_WIDTH:0]   MemAdresse,
    output logic [15:0]           MemDatenAus,
    input  logic [15:0]           MemDatenEin,
    output logic                  MemSchreiben,
    output logic                  MemLesen,
    output logic [1:0]            MemByteEnable
);
    typedef enum logic [2:0] {IDLE, LOW, HIGH, DONE, GAP} state_t;

    localparam int               CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [15:0]           dat_hi_q;
    logic [1:0]            msk_hi_q;
    logic                  wr_q;

    logic skip_lo_in;
    logic skip_hi_in;
    logic skip_hi_q;

`ifdef RAM_RESPONDER_MASK_SKIP_EN
    assign skip_lo_in = Schreiben && (WriteMask[1:0] == 2'b00);
    assign skip_hi_in = Schreiben && (WriteMask[3:2] == 2'b00);
    assign skip_hi_q  = wr_q && (msk_hi_q == 2'b00);
`else
    assign skip_lo_in = 1'b0;
    assign skip_hi_in = 1'b0;
    assign skip_hi_q  = 1'b0;
`endif

    // The low phase is set up straight from the request inputs, so only the high half is latched.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            LeseDaten     <= '0;
            RAMFertig     <= 1'b0;
            MemAdresse    <= '0;
            MemDatenAus   <= '0;
            MemSchreiben  <= 1'b0;
            MemLesen      <= 1'b0;
            MemByteEnable <= '0;
        end else begin
            RAMFertig <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Schreiben || Lesen) begin
                        adr_q    <= Adresse;
                        dat_hi_q <= SchreibDaten[31:16];
                        msk_hi_q <= WriteMask[3:2];
                        wr_q     <= Schreiben;
                        cnt_q    <= CNT_LOAD;
                        if (skip_lo_in && skip_hi_in) begin
                            state_q   <= DONE;
                            RAMFertig <= 1'b1;
                        end else if (skip_lo_in) begin
                            state_q       <= HIGH;
                            MemAdresse    <= {Adresse, 1'b1};
                            MemDatenAus   <= SchreibDaten[31:16];
                            MemByteEnable <= WriteMask[3:2];
                            MemSchreiben  <= 1'b1;
                            MemLesen      <= 1'b0;
                        end else begin
                            state_q       <= LOW;
                            MemAdresse    <= {Adresse, 1'b0};
                            MemDatenAus   <= SchreibDaten[15:0];
                            MemByteEnable <= Schreiben ? WriteMask[1:0] : 2'b11;
                            MemSchreiben  <= Schreiben;
                            MemLesen      <= !Schreiben;
                        end
                    end
                end
                LOW: begin
                    if (cnt_q == '0) begin
                        if (!wr_q) LeseDaten[15:0] <= MemDatenEin;
                        cnt_q <= CNT_LOAD;
                        if (skip_hi_q) begin
                            state_q       <= DONE;
                            RAMFertig     <= 1'b1;
                            MemSchreiben  <= 1'b0;
                            MemLesen      <= 1'b0;
                            MemByteEnable <= '0;
                        end else begin
                            state_q       <= HIGH;
                            MemAdresse    <= {adr_q, 1'b1};
                            MemDatenAus   <= dat_hi_q;
                            MemByteEnable <= wr_q ? msk_hi_q : 2'b11;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                HIGH: begin
                    if (cnt_q == '0) begin
                        if (!wr_q) LeseDaten[31:16] <= MemDatenEin;
                        state_q       <= DONE;
                        RAMFertig     <= 1'b1;
                        MemSchreiben  <= 1'b0;
                        MemLesen      <= 1'b0;
                        MemByteEnable <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                // The requester still holds its request during GAP, so it is not looked at there.
                DONE:    state_q <= GAP;
                GAP:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
